// File: rtl/led_trail_pkg.sv
// rtl/led_trail_pkg.sv - default parameters and derived constants for the LED trail block
package led_trail_pkg;
    localparam int NUM_LEDS       = 8;
    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_DECAY_DIV  = 2**20;
    localparam int DEF_DECAY_STEP = 32;
    localparam bit DEF_ACTIVE_LOW = 1'b1;
    localparam int DEF_MAX        = 2**DEF_PWM_BITS - 1;

    // Brightness after one decay tick, clamped at zero instead of wrapping.
    function automatic int sat_decay(input int level, input int step);
        return (level > step) ? (level - step) : 0;
    endfunction
endpackage

// File: rtl/led_trail_chan.sv
// rtl/led_trail_chan.sv - one LED channel: brightness load/decay, period-aligned duty, PWM compare
module led_trail_chan
    import led_trail_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                req,
    input  logic                tick,
    input  logic                capture,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                lit
);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] bright;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] decayed;

    assign decayed = PWM_BITS'(sat_decay(int'(bright), DECAY_STEP));

    // A request always wins over a decay tick landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bright <= '0;
        end else if (en) begin
            if (req) begin
                bright <= MAX;
            end else if (tick) begin
                bright <= decayed;
            end
        end
    end

    // Duty only follows brightness at the end of a PWM period so the waveform never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty <= '0;
        end else if (capture) begin
            duty <= bright;
        end
    end

    assign lit = (duty == MAX) || (pwm_cnt < duty);
endmodule

// File: rtl/led_trail.sv
// rtl/led_trail.sv - eight-LED fading trail: PWM counter, decay prescaler and registered LED outputs
module led_trail
    import led_trail_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int DECAY_DIV  = DEF_DECAY_DIV,
    parameter int DECAY_STEP = DEF_DECAY_STEP,
    parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_LEDS-1:0] pat_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                tick
);
    localparam int                PRE_W    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);
    localparam logic [NUM_LEDS-1:0] DARK   = {NUM_LEDS{ACTIVE_LOW}};

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    presc;
    logic                capture;
    logic [NUM_LEDS-1:0] lit;

    assign tick    = en && (presc == PRE_LAST);
    assign capture = en && (pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= tick ? '0 : presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_trail_chan #(
            .PWM_BITS  (PWM_BITS),
            .DECAY_STEP(DECAY_STEP)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .req    (pat_in[i]),
            .tick   (tick),
            .capture(capture),
            .pwm_cnt(pwm_cnt),
            .lit    (lit[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out <= DARK;
        end else if (en) begin
            led_out <= lit ^ DARK;
        end else begin
            led_out <= DARK;
        end
    end
endmodule

// File: tb/tb_led_trail.sv
// tb/tb_led_trail.sv - scoreboard bench for led_trail with an active-low and an active-high instance
module tb_led_trail;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pat_in;
    logic [7:0] led_a;
    logic [7:0] led_b;
    logic       tick_a;
    logic       tick_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    int div_p[2] = '{4, 16};
    bit al_p[2]  = '{1'b1, 1'b0};
    int m_pwm[2];
    int m_pre[2];
    int m_br[2][8];
    int m_du[2][8];
    logic last_tick[2];
    int exp_win[5] = '{16, 11, 7, 3, 0};

    always #5 clk = ~clk;

    led_trail #(.PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .pat_in(pat_in), .led_out(led_a), .tick(tick_a)
    );
    led_trail #(.PWM_BITS(4), .DECAY_DIV(16), .DECAY_STEP(4), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .pat_in(pat_in), .led_out(led_b), .tick(tick_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t e;
        e = sb.pop_front();
        check(e.tag, obs, e.val);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pwm[k] = 0;
            m_pre[k] = 0;
            for (int i = 0; i < 8; i++) begin
                m_br[k][i] = 0;
                m_du[k][i] = 0;
            end
        end
    endtask

    // One clock: inputs are set at the falling edge before this is called.
    task automatic cycle();
        bit         t[2];
        logic [7:0] nled;
        #1;
        for (int k = 0; k < 2; k++) begin
            t[k] = rst && en && (m_pre[k] == div_p[k] - 1);
            sb.push_back('{$sformatf("tick_%0d", k), {7'b0, t[k]}});
        end
        last_tick[0] = tick_a;
        last_tick[1] = tick_b;
        pop_check({7'b0, tick_a});
        pop_check({7'b0, tick_b});
        for (int k = 0; k < 2; k++) begin
            nled = {8{al_p[k]}};
            if (rst && en) begin
                for (int i = 0; i < 8; i++)
                    nled[i] = ((m_du[k][i] == 15) || (m_pwm[k] < m_du[k][i])) ^ al_p[k];
            end
            sb.push_back('{$sformatf("led_%0d", k), nled});
            if (!rst) begin
                m_pwm[k] = 0;
                m_pre[k] = 0;
                for (int i = 0; i < 8; i++) begin
                    m_br[k][i] = 0;
                    m_du[k][i] = 0;
                end
            end else if (en) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_pwm[k] == 15) m_du[k][i] = m_br[k][i];
                    if (pat_in[i]) m_br[k][i] = 15;
                    else if (t[k]) m_br[k][i] = (m_br[k][i] > 4) ? m_br[k][i] - 4 : 0;
                end
                m_pwm[k] = (m_pwm[k] + 1) % 16;
                m_pre[k] = t[k] ? 0 : m_pre[k] + 1;
            end
        end
        @(posedge clk);
        #1;
        pop_check(led_a);
        pop_check(led_b);
        @(negedge clk);
    endtask

    initial begin
        int         cnt;
        logic [7:0] p;
        rst = 1'b1;
        en = 1'b0;
        pat_in = 8'h00;
        #2 rst = 1'b0;
        #1;
        check("reset_led_a", led_a, 8'hFF);
        check("reset_led_b", led_b, 8'h00);
        check("reset_tick_a", {7'b0, tick_a}, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();

        // First enable: prescaler and PWM start together from zero.
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            pat_in = (c == 2) ? 8'h01 : 8'h00;
            cycle();
            check("tick_div4", {7'b0, last_tick[0]}, {7'b0, (c % 4) == 3});
            check("tick_div16", {7'b0, last_tick[1]}, {7'b0, c == 15});
        end
        pat_in = 8'h00;
        for (int w = 0; w < 5; w++) begin
            cnt = 0;
            for (int c = 0; c < 16; c++) begin
                cycle();
                if (led_b[0]) cnt++;
            end
            check($sformatf("lit_count_w%0d", w), 8'(cnt), 8'(exp_win[w]));
        end

        // Asynchronous reset in the middle of a decay.
        pat_in = 8'hFF;
        cycle();
        pat_in = 8'h00;
        for (int c = 0; c < 5; c++) cycle();
        #3 rst = 1'b0;
        #1;
        check("midreset_led_a", led_a, 8'hFF);
        check("midreset_led_b", led_b, 8'h00);
        check("midreset_tick_a", {7'b0, tick_a}, 8'h00);
        check("midreset_tick_b", {7'b0, tick_b}, 8'h00);
        model_reset();
        @(negedge clk);
        cycle();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("tick_after_reset", {7'b0, last_tick[0]}, {7'b0, c == 3});
        end

        // Request held across ticks keeps the channel at full brightness.
        for (int h = 0; h < 48; h++) begin
            pat_in = 8'h08;
            cycle();
            if (h >= 20) check("collision_led3", {7'b0, led_a[3]}, 8'h00);
        end
        pat_in = 8'h00;

        // Enable dropped mid-decay; requests during the pause are ignored.
        for (int c = 0; c < 6; c++) cycle();
        en = 1'b0;
        pat_in = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("pause_led_a", led_a, 8'hFF);
            check("pause_tick_a", {7'b0, last_tick[0]}, 8'h00);
        end
        en = 1'b1;
        pat_in = 8'h00;
        for (int c = 0; c < 40; c++) cycle();

        // Rotating upstream pattern.
        p = 8'h01;
        for (int r = 0; r < 128; r++) begin
            pat_in = p;
            cycle();
            if ((r % 8) == 7) p = {p[6:0], p[7]};
        end
        pat_in = 8'h00;
        for (int c = 0; c < 20; c++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
